shift_engine: RTL
=================

SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width (>=2).
REQ-002 SHALL have localparam AW = $clog2(WIDTH), width of shift-amount field.
REQ-003 SHALL have port Clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port Clear  input  1  asynchronous active-low reset.
REQ-005 SHALL have port Start  input  1  request; accepted only when engine is idle or done.
REQ-006 SHALL have port Op  input  3  operation: 0 NOP, 1 LOAD, 2 SHR, 3 SHL, 4 ROR, 5 ROL, 6 ASR, 7 LSL.
REQ-007 SHALL have port Amount  input  AW  shift count, 0..WIDTH-1.
REQ-008 SHALL have port D  input  WIDTH  parallel load data.
REQ-009 SHALL have port MSBIn  input  1  fill bit for SHR.
REQ-010 SHALL have port LSBIn  input  1  fill bit for SHL.
REQ-011 SHALL have port Q  output  WIDTH  register contents.
REQ-012 SHALL have port Busy  output  1  high while multi-cycle shift in progress.
REQ-013 SHALL have port Done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE; Busy=1 only in SHIFT, Done=1 only in DONE.
REQ-015 SHALL accept Start on a rising edge when state is IDLE or DONE; Start in SHIFT ignored without effect.
REQ-016 SHALL latch Op, Amount, MSBIn, LSBIn at acceptance; later input changes do not affect the operation.
REQ-017 LOAD SHALL write D to Q on the accepting edge and enter DONE.
REQ-018 NOP, or any shift op with Amount=0, SHALL leave Q unchanged and enter DONE on the accepting edge.
REQ-019 Shift op with Amount=A>=1 SHALL enter SHIFT with counter=A; one single-bit step applied per subsequent edge; edge applying step A enters DONE (Busy high exactly A cycles).
REQ-020 Single-bit steps SHALL be: SHR Q={MSBIn,Q[W-1:1]}; SHL {Q[W-2:0],LSBIn}; ROR {Q[0],Q[W-1:1]}; ROL {Q[W-2:0],Q[W-1]}; ASR {Q[W-1],Q[W-1:1]}; LSL {Q[W-2:0],1'b0}.
REQ-021 DONE SHALL last one cycle, returning to IDLE unless Start accepted on that edge (back-to-back allowed; Done then low next cycle for shift ops, high again for LOAD/NOP/Amount=0).
REQ-022 Amount values >= WIDTH (non-power-of-2 WIDTH) SHALL saturate to WIDTH-1.
REQ-023 Q SHALL change only on LOAD edges, SHIFT steps, or reset.

Reset
REQ-024 Clear low SHALL immediately force Q=0, state IDLE, counter=0, Busy=0, Done=0 (and Carry=0 when enabled), regardless of state.
REQ-025 Clear released mid-operation SHALL leave engine idle; aborted operation never resumes, no Done pulse produced.

Configuration
REQ-026 Macro SHIFT_ENGINE_CARRY_EN defined SHALL add output Carry (1 bit): bit shifted/rotated out of Q on each step, holds last step's value; LOAD clears it to 0; NOP/Amount=0 leave it unchanged.
REQ-027 Macro SHIFT_ENGINE_CARRY_EN undefined SHALL remove Carry port and its flop; all other behaviour identical.

Structure
REQ-028 Package shift_engine_pkg SHALL hold op enum (NOP..LSL, 3-bit) and FSM state enum.
REQ-029 Combinational one-step shifter SHALL be sub-module shift_step (inputs Q, op, MSBIn, LSBIn; outputs next Q, out bit), instantiated once.

Verification (WIDTH=8)
REQ-030 LOAD D=8'hA5 -> Q=8'hA5 after accepting edge; Done high exactly next cycle; Busy never high.
REQ-031 From 8'hA5, ROL Amount=3 -> Busy high 3 cycles, Q=8'h2D, then one Done pulse; Start pulsed during Busy ignored.
REQ-032 From 8'h96, ASR Amount=2 -> Q=8'hE5; Carry=1 when SHIFT_ENGINE_CARRY_EN defined.
REQ-033 From 8'h00, SHL Amount=7 LSBIn=1 (LSBIn driven 0 after acceptance) -> Q=8'h7F.
REQ-034 From 8'hFF, SHR Amount=5 MSBIn=0, Clear low after 2 steps -> Q=8'h00, Busy=0, no Done; next LOAD accepted normally.
REQ-035 From 8'h3C, SHR Amount=0 -> Q stays 8'h3C, Done high cycle after Start, Busy never high.

Source files
------------

// File: rtl/shift_engine_pkg.sv
// Shared types for the shift engine: operation codes and controller states.
package shift_engine_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHR  = 3'd2,
        OP_SHL  = 3'd3,
        OP_ROR  = 3'd4,
        OP_ROL  = 3'd5,
        OP_ASR  = 3'd6,
        OP_LSL  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_engine_shift_step.sv
// Combinational single-bit shifter: one step of the selected operation plus
// the bit that leaves the register on that step.
module shift_step
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  op_e              op,
    input  logic             msb_in,
    input  logic             lsb_in,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        case (op)
            OP_SHR: begin q_next = {msb_in, q[WIDTH-1:1]};   out_bit = q[0];       end
            OP_SHL: begin q_next = {q[WIDTH-2:0], lsb_in};   out_bit = q[WIDTH-1]; end
            OP_ROR: begin q_next = {q[0], q[WIDTH-1:1]};     out_bit = q[0];       end
            OP_ROL: begin q_next = {q[WIDTH-2:0], q[WIDTH-1]}; out_bit = q[WIDTH-1]; end
            OP_ASR: begin q_next = {q[WIDTH-1], q[WIDTH-1:1]}; out_bit = q[0];     end
            OP_LSL: begin q_next = {q[WIDTH-2:0], 1'b0};     out_bit = q[WIDTH-1]; end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// Multi-cycle shift/rotate engine: one bit per clock, Busy while shifting, Done pulse.
// Optional Carry output is built when SHIFT_ENGINE_CARRY_EN is defined.
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [AW-1:0]    Amount,
    input  logic [WIDTH-1:0] D,
    input  logic             MSBIn,
    input  logic             LSBIn,
    output logic [WIDTH-1:0] Q,
    output logic             Busy,
    output logic             Done
`ifdef SHIFT_ENGINE_CARRY_EN
    ,
    output logic             Carry
`endif
);

    state_e            state;
    logic [AW-1:0]     count;
    op_e               op_r;
    logic              msb_r;
    logic              lsb_r;
    op_e               op_in;
    logic [AW-1:0]     amount_sat;
    logic [WIDTH-1:0]  step_q;
    logic              step_out;

    assign op_in = op_e'(Op);

    // Only reachable for non-power-of-two WIDTH; clamps to the longest legal shift.
    assign amount_sat = (32'(Amount) > WIDTH - 1) ? AW'(WIDTH - 1) : Amount;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .q      (Q),
        .op     (op_r),
        .msb_in (msb_r),
        .lsb_in (lsb_r),
        .q_next (step_q),
        .out_bit(step_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state <= ST_IDLE;
            Q     <= '0;
            count <= '0;
            op_r  <= OP_NOP;
            msb_r <= 1'b0;
            lsb_r <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    Q     <= step_q;
                    count <= count - AW'(1);
                    if (count == AW'(1)) begin
                        state <= ST_DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    state <= ST_IDLE;
                    Done  <= 1'b0;
                    if (Start) begin
                        op_r  <= op_in;
                        msb_r <= MSBIn;
                        lsb_r <= LSBIn;
                        if (op_in == OP_LOAD) begin
                            Q     <= D;
                            state <= ST_DONE;
                            Done  <= 1'b1;
                        end else if (op_in == OP_NOP || amount_sat == '0) begin
                            state <= ST_DONE;
                            Done  <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                            count <= amount_sat;
                            Busy  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef SHIFT_ENGINE_CARRY_EN
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            Carry <= 1'b0;
        end else if (state == ST_SHIFT) begin
            Carry <= step_out;
        end else if (Start && op_in == OP_LOAD) begin
            Carry <= 1'b0;
        end
    end
`else
    logic unused_carry;
    assign unused_carry = step_out;
`endif

endmodule
